// File: rtl/pito_mvu_apb_arbiter_if.sv
// Hart-side request/response bundle plus the APB master bus of the MVU config port.
// master: the arbiter's view. slave: the environment (harts and the APB completer).
interface pito_mvu_apb_arbiter_if #(
  parameter int NUM_HARTS      = 8,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
);
  localparam int IDW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  logic [NUM_HARTS-1:0]                     req_valid;
  logic [NUM_HARTS-1:0]                     req_write;
  logic [NUM_HARTS-1:0][APB_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_HARTS-1:0][APB_DATA_WIDTH-1:0] req_wdata;
  logic [NUM_HARTS-1:0]                     req_ready;
  logic [NUM_HARTS-1:0]                     rsp_valid;
  logic [APB_DATA_WIDTH-1:0]                rsp_rdata;
  logic                                     rsp_err;
  logic [IDW-1:0]                           grant_id;
  logic                                     busy;
  logic                                     psel;
  logic                                     penable;
  logic                                     pwrite;
  logic [APB_ADDR_WIDTH-1:0]                paddr;
  logic [APB_DATA_WIDTH-1:0]                pwdata;
  logic [APB_DATA_WIDTH-1:0]                prdata;
  logic                                     pready;
  logic                                     pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id, busy,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id, busy,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/pito_mvu_apb_arbiter.sv
// Round-robin arbiter sharing the single MVU APB config port among NUM_HARTS harts.
// Define PITO_APB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYCLES wait cycles.
module pito_mvu_apb_arbiter #(
  parameter int NUM_HARTS      = 8,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                    clk,
  input logic                    rst_n,
  pito_mvu_apb_arbiter_if.master bus
);
  localparam int IDW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
  localparam int PW  = IDW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                    state, state_nxt;
  logic [IDW-1:0]            rr_ptr, gid_q, gnt;
  logic                      any_vld;
  logic [2*NUM_HARTS-1:0]    req2;
  logic [PW-1:0]             pos;
  logic                      lat_write;
  logic [APB_ADDR_WIDTH-1:0] lat_addr;
  logic [APB_DATA_WIDTH-1:0] lat_wdata;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;
  logic                      to_hit;

  // Doubled request vector turns the wrap-around search into a linear scan.
  assign req2 = {bus.req_valid, bus.req_valid};

  always_comb begin
    any_vld = 1'b0;
    gnt     = '0;
    pos     = '0;
    for (int k = 1; k <= NUM_HARTS; k++) begin
      pos = {1'b0, rr_ptr} + PW'(k);
      if (!any_vld && req2[pos]) begin
        any_vld = 1'b1;
        gnt     = (pos >= PW'(NUM_HARTS)) ? IDW'(pos - PW'(NUM_HARTS)) : IDW'(pos);
      end
    end
  end

`ifdef PITO_APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  // Zero outside ACCESS, so it is already clear on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          to_cnt <= '0;
    else if (state != ACCESS)            to_cnt <= '0;
    else if (!bus.pready)                to_cnt <= to_cnt + CW'(1);
  end

  assign to_hit = (state == ACCESS) && !bus.pready && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign to_hit         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_vld) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (bus.pready || to_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accept pulse is gated by reset so every output reads 0 while held in reset.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.psel      = 1'b0;
    bus.penable   = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE:    if (any_vld && rst_n) bus.req_ready[gnt] = 1'b1;
      SETUP:   bus.psel = 1'b1;
      ACCESS:  begin bus.psel = 1'b1; bus.penable = 1'b1; end
      RESP:    bus.rsp_valid[gid_q] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= IDW'(NUM_HARTS - 1);
      gid_q     <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == IDLE && any_vld) begin
        rr_ptr    <= gnt;
        gid_q     <= gnt;
        lat_write <= bus.req_write[gnt];
        lat_addr  <= bus.req_addr[gnt];
        lat_wdata <= bus.req_wdata[gnt];
      end
      if (state == ACCESS) begin
        if (bus.pready) begin
          rdata_q <= lat_write ? '0 : bus.prdata;
          err_q   <= bus.pslverr;
        end else if (to_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.grant_id  = gid_q;
  assign bus.pwrite    = lat_write;
  assign bus.paddr     = lat_addr;
  assign bus.pwdata    = lat_wdata;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_pito_mvu_apb_arbiter.sv
// Bench for pito_mvu_apb_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level round-robin/APB reference model.
module tb_pito_mvu_apb_arbiter;
  localparam int N  = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pito_mvu_apb_arbiter_if #(.NUM_HARTS(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

  pito_mvu_apb_arbiter #(
    .NUM_HARTS(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  typedef struct {
    logic [N-1:0]  mask;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] s_rdata;
    int            s_wait;
    logic          s_err;
    int            exp_g;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t tbl [8];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int g);
    return N'(1) << g;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    int r = -1;
    for (int h = 0; h < N; h++) if (v[h]) r = h;
    return r;
  endfunction

  // Winner = valid hart at the smallest forward distance past the last grantee.
  function automatic int pick(input logic [N-1:0] v, input int last);
    int best = -1;
    int bd = N;
    for (int h = 0; h < N; h++) begin
      if (v[h] && ((h - last - 1 + 2 * N) % N) < bd) begin
        bd   = (h - last - 1 + 2 * N) % N;
        best = h;
      end
    end
    return best;
  endfunction

  task automatic clr_inputs();
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One full transfer with hand-computed expectations; starts away from a clock edge.
  task automatic xfer(input vec_t v, input string tag);
    bus.req_valid = v.mask;
    for (int h = 0; h < N; h++) begin
      bus.req_write[h] = v.wr;
      bus.req_addr[h]  = v.addr;
      bus.req_wdata[h] = v.wdata;
    end
    bus.pready = 1'b0;
    #1;
    chk({tag, "_accept"}, bus.req_ready, oh(v.exp_g));
    chk({tag, "_idle_busy"}, bus.busy, 0);
    @(posedge clk); #1 bus.req_valid = '0;
    @(negedge clk);
    chk({tag, "_setup_psel"}, {bus.psel, bus.penable}, 2'b10);
    chk({tag, "_setup_paddr"}, bus.paddr, v.addr);
    chk({tag, "_grant_id"}, bus.grant_id, v.exp_g);
    for (int k = 0; k <= v.s_wait; k++) begin
      @(negedge clk);
      chk({tag, "_access_psel"}, {bus.psel, bus.penable}, 2'b11);
      chk({tag, "_access_paddr"}, bus.paddr, v.addr);
      chk({tag, "_access_pwrite"}, bus.pwrite, v.wr);
      if (v.wr) chk({tag, "_access_pwdata"}, bus.pwdata, v.wdata);
      chk({tag, "_access_norsp"}, bus.rsp_valid, 0);
      if (k == v.s_wait) begin
        bus.pready = 1'b1; bus.prdata = v.s_rdata; bus.pslverr = v.s_err;
      end else begin
        bus.pready = 1'b0; bus.prdata = $urandom; bus.pslverr = 1'($urandom);
      end
      @(posedge clk); #1 bus.pready = 1'b0; bus.pslverr = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, oh(v.exp_g));
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({tag, "_rsp_err"}, bus.rsp_err, v.exp_err);
    chk({tag, "_rsp_psel"}, {bus.psel, bus.penable}, 2'b00);
    @(negedge clk);
    chk({tag, "_after_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_hold_rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({tag, "_after_busy"}, bus.busy, 0);
  endtask

  task automatic all_harts_test();
    int gseq[$];
    int gcyc[$];
    int rsp_cnt[N];
    int g;
    for (int h = 0; h < N; h++) rsp_cnt[h] = 0;
    do_reset();
    bus.req_valid = '1;
    for (int h = 0; h < N; h++) bus.req_addr[h] = AW'(h * 4);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.pready = bus.psel && bus.penable;
      bus.prdata = DW'(c);
      g = idx_of(bus.req_ready);
      if (g >= 0) begin
        chk("all_ready_onehot", $countones(bus.req_ready), 1);
        gseq.push_back(g);
        gcyc.push_back(c);
      end
      for (int h = 0; h < N; h++) if (bus.rsp_valid[h]) rsp_cnt[h]++;
      @(posedge clk); #1;
      if (g >= 0) bus.req_valid[g] = 1'b0;
    end
    bus.pready = 1'b0;
    chk("all_grant_count", gseq.size(), N);
    for (int i = 0; i < gseq.size() && i < N; i++) begin
      chk("all_grant_order", gseq[i], i);
      chk("all_grant_cycle", gcyc[i], 4 * i);
    end
    for (int h = 0; h < N; h++) chk("all_rsp_once", rsp_cnt[h], 1);
  endtask

  task automatic alt_test();
    int gseq[$];
    int g;
    do_reset();
    bus.req_valid = 8'h24;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      bus.pready = bus.psel && bus.penable;
      g = idx_of(bus.req_ready);
      if (g >= 0) gseq.push_back(g);
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    bus.pready = 1'b0;
    chk("alt_count", gseq.size() >= 6, 1);
    for (int i = 0; i < gseq.size() && i < 6; i++) chk("alt_order", gseq[i], (i % 2 == 0) ? 2 : 5);
    @(negedge clk); @(negedge clk); @(negedge clk);
  endtask

  task automatic reset_mid_test();
    vec_t v;
    int rsp = 0;
    do_reset();
    bus.req_valid = 8'h10;
    bus.pready = 1'b0;
    #1 chk("rmid_accept", bus.req_ready, 8'h10);
    @(posedge clk); #1 bus.req_valid = '0;
    @(negedge clk); @(negedge clk);
    chk("rmid_access", {bus.psel, bus.penable}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("rmid_async_psel", {bus.psel, bus.penable}, 2'b00);
    chk("rmid_async_busy", bus.busy, 0);
    repeat (2) begin @(negedge clk); if (bus.rsp_valid != 0) rsp++; end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (bus.rsp_valid != 0) rsp++; end
    chk("rmid_no_rsp", rsp, 0);
    v = '{8'h30, 1'b0, 32'h50, 32'h0, 32'h0BADF00D, 0, 1'b0, 4, 32'h0BADF00D, 1'b0};
    xfer(v, "rmid_after");
  endtask

  task automatic timeout_test();
    int acc = 0;
    int rsp = 0;
    do_reset();
    bus.req_valid = 8'h01;
    bus.req_addr[0] = 32'h40;
    #1 chk("to_accept", bus.req_ready, 8'h01);
    @(posedge clk); #1 bus.req_valid = '0;
`ifdef PITO_APB_TIMEOUT_EN
    for (int c = 0; c < 100 && rsp == 0; c++) begin
      @(negedge clk);
      bus.prdata = $urandom;
      if (bus.psel && bus.penable) acc++;
      else if (bus.rsp_valid != 0) begin
        rsp = 1;
        chk("to_rsp_valid", bus.rsp_valid, 8'h01);
        chk("to_rsp_err", bus.rsp_err, 1);
        chk("to_rsp_rdata", bus.rsp_rdata, 0);
        bus.pready = 1'b1;
      end
    end
    chk("to_access_cycles", acc, TO);
    chk("to_rsp_seen", rsp, 1);
    @(posedge clk); #1 bus.pready = 1'b0;
    @(negedge clk);
    chk("to_late_ready_ignored", bus.rsp_valid, 0);
    chk("to_idle", bus.busy, 0);
`else
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c > 0 && bus.psel) acc++;
      if (bus.rsp_valid != 0) rsp++;
    end
    chk("nto_psel_held", acc, 999);
    chk("nto_still_access", {bus.psel, bus.penable}, 2'b11);
    chk("nto_no_rsp", rsp, 0);
    do_reset();
`endif
  endtask

  task automatic rand_test(input int cycles);
    logic [DW-1:0] smem [16];
    logic [DW-1:0] mmem [16];
    logic [N-1:0]  outst = '0;
    int last = N - 1, gid = 0, t_acc = 0, w = 0, p_wait = 0, acc_cnt = 0, ph, eg;
    bit inflight = 0, p_wr = 0, p_err = 0, acc_now, rsp_now, last_err = 0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0, exp_rd = '0, last_rd = '0;
    for (int i = 0; i < 16; i++) begin smem[i] = $urandom; mmem[i] = smem[i]; end
    do_reset();
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(negedge clk);
      acc_now = 0; rsp_now = 0;
      if (bus.psel && bus.penable) begin
        if (acc_cnt >= p_wait) begin
          bus.pready = 1'b1; bus.pslverr = p_err;
          bus.prdata = bus.pwrite ? DW'($urandom) : smem[bus.paddr[5:2]];
          if (bus.pwrite) smem[bus.paddr[5:2]] = bus.pwdata;
        end else begin
          bus.pready = 1'b0; bus.prdata = $urandom; bus.pslverr = 1'($urandom);
        end
        acc_cnt++;
      end else begin
        bus.pready = 1'b0; acc_cnt = 0;
      end
      if (!inflight) begin
        eg = pick(bus.req_valid, last);
        chk("rnd_ready", bus.req_ready, (eg < 0) ? '0 : oh(eg));
        chk("rnd_idle_busy", bus.busy, 0);
        chk("rnd_idle_psel", bus.psel, 0);
        chk("rnd_idle_rsp", bus.rsp_valid, 0);
        chk("rnd_hold_rdata", bus.rsp_rdata, last_rd);
        chk("rnd_hold_err", bus.rsp_err, last_err);
        chk("rnd_idle_gid", bus.grant_id, gid);
        if (eg >= 0) begin
          inflight = 1; acc_now = 1; t_acc = cyc; w = eg; last = eg; gid = eg;
          p_wr = bus.req_write[eg]; p_addr = bus.req_addr[eg]; p_wdata = bus.req_wdata[eg];
          p_wait = $urandom_range(0, 3);
          p_err = ($urandom_range(0, 3) == 0);
          exp_rd = p_wr ? '0 : mmem[p_addr[5:2]];
          if (p_wr) mmem[p_addr[5:2]] = p_wdata;
        end
      end else begin
        ph = cyc - t_acc;
        chk("rnd_busy", bus.busy, 1);
        chk("rnd_no_ready", bus.req_ready, 0);
        chk("rnd_gid", bus.grant_id, gid);
        if (ph == 1) begin
          chk("rnd_setup", {bus.psel, bus.penable}, 2'b10);
          chk("rnd_setup_paddr", bus.paddr, p_addr);
        end else if (ph <= 2 + p_wait) begin
          chk("rnd_access", {bus.psel, bus.penable}, 2'b11);
          chk("rnd_access_paddr", bus.paddr, p_addr);
          chk("rnd_access_pwrite", bus.pwrite, p_wr);
          if (p_wr) chk("rnd_access_pwdata", bus.pwdata, p_wdata);
        end else begin
          chk("rnd_rsp_valid", bus.rsp_valid, oh(w));
          chk("rnd_rsp_rdata", bus.rsp_rdata, exp_rd);
          chk("rnd_rsp_err", bus.rsp_err, p_err);
          chk("rnd_rsp_psel", bus.psel, 0);
          last_rd = exp_rd; last_err = p_err; inflight = 0; rsp_now = 1;
        end
        if (!rsp_now) chk("rnd_no_rsp", bus.rsp_valid, 0);
      end
      @(posedge clk); #1;
      if (acc_now) begin bus.req_valid[w] = 1'b0; outst[w] = 1'b1; end
      if (rsp_now) outst[w] = 1'b0;
      for (int h = 0; h < N; h++) begin
        if (!bus.req_valid[h] && !outst[h]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.req_valid[h] = 1'b1;
            bus.req_write[h] = 1'($urandom);
            bus.req_addr[h]  = AW'($urandom_range(0, 15) * 4);
            bus.req_wdata[h] = $urandom;
          end
        end else if (bus.req_valid[h] && $urandom_range(0, 15) == 0) begin
          bus.req_valid[h] = 1'b0;
        end
      end
    end
    clr_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h08, 1'b0, 32'h10, 32'h00, 32'hDEADBEEF, 0, 1'b0, 3, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{8'h02, 1'b1, 32'h04, 32'h5A, 32'h11111111, 3, 1'b1, 1, 32'h0, 1'b1};
    tbl[2] = '{8'h81, 1'b0, 32'h20, 32'h00, 32'h00001234, 1, 1'b0, 7, 32'h00001234, 1'b0};
    tbl[3] = '{8'h81, 1'b0, 32'h24, 32'h00, 32'hCAFE0003, 0, 1'b0, 0, 32'hCAFE0003, 1'b0};
    tbl[4] = '{8'h05, 1'b1, 32'h28, 32'hAB, 32'hFFFFFFFF, 2, 1'b0, 2, 32'h0, 1'b0};
    tbl[5] = '{8'h05, 1'b0, 32'h2C, 32'h00, 32'hCAFE0005, 0, 1'b0, 0, 32'hCAFE0005, 1'b0};
    tbl[6] = '{8'hFF, 1'b0, 32'h30, 32'h00, 32'hA5A5A5A5, 0, 1'b0, 1, 32'hA5A5A5A5, 1'b0};
    tbl[7] = '{8'h40, 1'b0, 32'h34, 32'h00, 32'h00000055, 1, 1'b1, 6, 32'h00000055, 1'b1};

    rst_n = 1'b0;
    clr_inputs();
    bus.req_valid = '1;
    bus.req_write = '1;
    #3;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_psel_penable", {bus.psel, bus.penable}, 0);
    chk("rst_pwrite", bus.pwrite, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    do_reset();

    for (int i = 0; i < 8; i++) xfer(tbl[i], $sformatf("vec%0d", i));
    all_harts_test();
    alt_test();
    reset_mid_test();
    timeout_test();
    rand_test(3000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pito_mvu_apb_arbiter.md
Name: pito_mvu_apb_arbiter

Overview:
- Shares the single MVU APB configuration port of pito_soc between NUM_HARTS hart-side requesters.
- Round-robin arbitration; sequences each accepted request through a standard APB SETUP/ACCESS transfer; returns read data and error status to the winning hart.
- Sits between the per-hart CSR/MMIO request logic and the APB master port toward the MVU.

Parameters:
- NUM_HARTS, 8, number of requesters.
- APB_ADDR_WIDTH, pito_pkg::APB_ADDR_WIDTH, APB address width.
- APB_DATA_WIDTH, pito_pkg::APB_DATA_WIDTH, APB data width.
- TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit; used only with the optional feature.

Ports:
- sys_clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_HARTS  per-hart request pending.
- req_write_i  in  NUM_HARTS  per-hart 1=write, 0=read.
- req_addr_i  in  NUM_HARTS*APB_ADDR_WIDTH  per-hart address, hart h at slice h.
- req_wdata_i  in  NUM_HARTS*APB_DATA_WIDTH  per-hart write data.
- req_ready_o  out  NUM_HARTS  one-hot, one-cycle accept pulse.
- rsp_valid_o  out  NUM_HARTS  one-hot, one-cycle completion pulse.
- rsp_rdata_o  out  APB_DATA_WIDTH  read data, valid with rsp_valid_o.
- rsp_err_o  out  1  slave error or timeout, valid with rsp_valid_o.
- grant_id_o  out  $clog2(NUM_HARTS)  index of the hart owning the bus.
- busy_o  out  1  high when the FSM is not IDLE.
- psel_o, penable_o, pwrite_o  out  1 each  APB controls.
- paddr_o  out  APB_ADDR_WIDTH  APB address.
- pwdata_o  out  APB_DATA_WIDTH  APB write data.
- prdata_i  in  APB_DATA_WIDTH  APB read data.
- pready_i, pslverr_i  in  1 each  APB ready and slave error.

Behaviour:
- Reset (async, rst_n_i low): all outputs 0; FSM=IDLE; rr_ptr=NUM_HARTS-1, so hart 0 has first priority.
- A reset asserted mid-transfer drops psel_o/penable_o immediately and discards the request. No rsp_valid_o is produced.
- IDLE:
  - If any req_valid_i is set, grant the first set bit searching from rr_ptr+1 upward, wrapping NUM_HARTS-1 to 0.
  - Pulse req_ready_o[g] this cycle (combinational from registered state plus req_valid_i).
  - Latch write/addr/wdata of hart g. rr_ptr<=g; grant_id_o<=g; go SETUP.
- SETUP: psel_o=1, penable_o=0, paddr_o/pwrite_o/pwdata_o from latched values; go ACCESS next cycle.
- ACCESS: psel_o=1, penable_o=1.
  - Hold all APB outputs stable while pready_i=0.
  - On pready_i=1: capture prdata_i (reads only; writes return 0) and pslverr_i; go RESP.
- RESP: psel_o=penable_o=0; rsp_valid_o[g]=1 for one cycle with rsp_rdata_o/rsp_err_o; go IDLE.
- rsp_rdata_o/rsp_err_o hold their last value outside RESP.
- Latency with zero-wait slave: accept at cycle 0, SETUP cycle 1, ACCESS cycle 2, RESP cycle 3. Minimum issue interval is 4 cycles per transfer.
- Requesters hold req_valid_i and payload until req_ready_o. Deasserting req_valid_i before accept is legal and is simply not granted.
- A hart re-requesting after RESP is not starved: rr_ptr rotation guarantees every valid hart a grant within NUM_HARTS transfers.
- Only one transfer is outstanding at a time; no APB pipelining.

Optional Feature:
- Macro PITO_APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle with pready_i=0.
  - When it reaches TIMEOUT_CYCLES: drop psel_o/penable_o, go RESP with rsp_err_o=1 and rsp_rdata_o=0.
  - A late pready_i is ignored.
- Undefined: no counter; ACCESS waits indefinitely for pready_i.

Test Plan:
- Single read, hart 3, addr 0x10, slave returns 0xDEADBEEF with pready=1 in ACCESS -> req_ready_o=0x08 at cycle 0; psel 1/penable 0 at cycle 1; penable 1 at cycle 2; rsp_valid_o=0x08 with rdata 0xDEADBEEF, err 0 at cycle 3.
- All 8 harts request simultaneously from reset, zero-wait slave -> grants in order 0,1,...,7, each 4 cycles apart; each hart gets exactly one rsp_valid_o pulse.
- Harts 2 and 5 continuously re-request -> grants alternate 2,5,2,5; no hart receives two consecutive grants.
- Write hart 1, addr 0x04, wdata 0x5A, slave holds pready=0 for 3 ACCESS cycles then pslverr=1 -> paddr/pwdata/pwrite stable throughout; rsp_valid_o=0x02, rsp_err_o=1, rsp_rdata_o=0.
- rst_n_i pulsed low during ACCESS -> psel/penable fall asynchronously; no rsp_valid_o; next request after reset is granted to the lowest-index valid hart.
- With PITO_APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never ready -> psel drops after 16 ACCESS cycles; rsp_err_o=1, rdata 0. Without the macro, the bench observes psel held high for 1000 cycles.
